// File: rtl/universal_counter.sv
// Modulo-M up/down counter with parallel load, synchronous clear and a
// one-shot mode that halts at the terminal count instead of wrapping.
module universal_counter #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         up,
  input  logic         oneshot,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         wrap,
  output logic         done
);

  if ((M < 2) || (longint'(M) > (longint'(1) << N))) begin : g_bad_modulus
    $error("universal_counter: M must lie in 2 .. 2**N");
  end

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHalt = 1'b1;

  localparam logic [N-1:0] MaxVal = N'(M - 1);
  localparam logic [N-1:0] One    = N'(1);
  localparam logic [N:0]   ModVal = (N + 1)'(M);

  logic [N-1:0] count_q, count_d;
  logic [0:0]   state_q, state_d;
  logic         wrap_q, wrap_d;
  logic         load_over;

  // Load values outside the modulus saturate to the terminal count.
  assign load_over = ({1'b0, d} >= ModVal);

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = '0;
      state_d = StRun;
    end else if (load) begin
      count_d = load_over ? MaxVal : d;
      state_d = StRun;
    end else if ((state_q == StRun) && en) begin
      if (up) begin
        if (count_q == MaxVal) begin
          if (oneshot) begin
            state_d = StHalt;
          end else begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + One;
        end
      end else begin
        if (count_q == '0) begin
          if (oneshot) begin
            state_d = StHalt;
          end else begin
            count_d = MaxVal;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - One;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      state_q <= StRun;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q        = count_q;
  assign max_tick = (count_q == MaxVal);
  assign min_tick = (count_q == '0);
  assign wrap     = wrap_q;
  assign done     = (state_q == StHalt);

endmodule

// File: tb/tb_universal_counter.sv
// Directed bench: three counters (M=10, M=6, M=256) share one set of controls;
// each step names the instance it checks.
module tb_universal_counter;

  logic       clk = 1'b0;
  logic       rst, en, clr, load, up, oneshot;
  logic [7:0] d8;

  logic [3:0] q10, q6;
  logic [7:0] q256;
  logic       max10, min10, wrap10, done10;
  logic       max6, min6, wrap6, done6;
  logic       max256, min256, wrap256, done256;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  universal_counter #(.N(4), .M(10)) u_m10 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .d(d8[3:0]), .up(up),
    .oneshot(oneshot), .q(q10), .max_tick(max10), .min_tick(min10), .wrap(wrap10),
    .done(done10)
  );

  universal_counter #(.N(4), .M(6)) u_m6 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .d(d8[3:0]), .up(up),
    .oneshot(oneshot), .q(q6), .max_tick(max6), .min_tick(min6), .wrap(wrap6),
    .done(done6)
  );

  universal_counter #(.N(8), .M(256)) u_m256 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .d(d8), .up(up),
    .oneshot(oneshot), .q(q256), .max_tick(max256), .min_tick(min256), .wrap(wrap256),
    .done(done256)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; up = 1'b1; oneshot = 1'b0;
    d8 = 8'd0;
    #2;
    chk("rst_q",    32'(q10),    0);
    chk("rst_max",  32'(max10),  0);
    chk("rst_min",  32'(min10),  1);
    chk("rst_wrap", 32'(wrap10), 0);
    chk("rst_done", 32'(done10), 0);
    @(negedge clk);
    rst = 1'b0;

    // Free-running up count, M=10: 1..9, 0, 1, 2 with a wrap pulse on q=0.
    en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("up_q",    32'(q10),    32'(i % 10));
      chk("up_max",  32'(max10),  32'((i % 10) == 9));
      chk("up_wrap", 32'(wrap10), 32'(i == 10));
    end

    // Down count from reset wraps straight to 9.
    en = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    chk("dn_min_before", 32'(min10), 1);
    up = 1'b0; en = 1'b1;
    step();
    chk("dn_q0",    32'(q10),    9);
    chk("dn_wrap0", 32'(wrap10), 1);
    step();
    chk("dn_q1",    32'(q10),    8);
    chk("dn_wrap1", 32'(wrap10), 0);

    // One-shot: load 7, count to 9, halt there.
    en = 1'b0; up = 1'b1; oneshot = 1'b1; load = 1'b1; d8 = 8'd7;
    step();
    load = 1'b0;
    chk("os_load_q", 32'(q10), 7);
    en = 1'b1;
    step();
    chk("os_q8", 32'(q10), 8);
    step();
    chk("os_q9",     32'(q10),   9);
    chk("os_max9",   32'(max10), 1);
    chk("os_done_0", 32'(done10), 0);
    step();
    chk("os_hold_q",  32'(q10),    9);
    chk("os_done_1",  32'(done10), 1);
    chk("os_no_wrap", 32'(wrap10), 0);
    en = 1'b0;
    step();
    chk("os_en0_q",    32'(q10),    9);
    chk("os_en0_done", 32'(done10), 1);
    en = 1'b1; up = 1'b0; oneshot = 1'b0;
    step();
    chk("os_ign_q",    32'(q10),    9);
    chk("os_ign_done", 32'(done10), 1);
    chk("os_ign_wrap", 32'(wrap10), 0);
    clr = 1'b1;
    step();
    clr = 1'b0; en = 1'b0;
    chk("os_clr_q",    32'(q10),    0);
    chk("os_clr_done", 32'(done10), 0);

    // Load saturation and clr-over-load priority.
    load = 1'b1; d8 = 8'd12;
    step();
    chk("ld_sat_q", 32'(q10), 9);
    chk("ld_sat_6", 32'(q6),  5);
    clr = 1'b1; d8 = 8'd3;
    step();
    clr = 1'b0; load = 1'b0;
    chk("clr_ld_q", 32'(q10), 0);

    // Async reset while halted at 5 (M=6), then resume from 0.
    up = 1'b1; oneshot = 1'b1; load = 1'b1; d8 = 8'd5;
    step();
    load = 1'b0; en = 1'b1;
    step();
    chk("ar_pre_q",    32'(q6),    5);
    chk("ar_pre_done", 32'(done6), 1);
    en = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("ar_q",    32'(q6),    0);
    chk("ar_done", 32'(done6), 0);
    chk("ar_min",  32'(min6),  1);
    #2 rst = 1'b0;
    oneshot = 1'b0; en = 1'b1;
    step();
    chk("ar_resume_q", 32'(q6), 1);

    // M=256 binary rollover.
    en = 1'b0; load = 1'b1; d8 = 8'd253;
    step();
    load = 1'b0; en = 1'b1;
    chk("b_load", 32'(q256), 253);
    step();
    chk("b_254", 32'(q256), 254);
    step();
    chk("b_255",     32'(q256),   255);
    chk("b_max",     32'(max256), 1);
    chk("b_nowrap",  32'(wrap256), 0);
    step();
    chk("b_0",      32'(q256),    0);
    chk("b_wrap",   32'(wrap256), 1);
    chk("b_min",    32'(min256),  1);
    step();
    chk("b_1",      32'(q256),    1);
    chk("b_wrap_end", 32'(wrap256), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/universal_counter.md
UNIVERSAL_COUNTER -- requirements
Module: universal_counter

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the counter width in bits.
REQ-002 The block SHALL have parameter M, default 256, giving the count modulus; legal range 2 to 2**N; an out-of-range M SHALL cause an elaboration error.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state updates occur on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-008 The block SHALL have port d, input, N bits: parallel load value.
REQ-009 The block SHALL have port up, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-010 The block SHALL have port oneshot, input, 1 bit: mode; 0 wraps at the terminal count, 1 halts at the terminal count.
REQ-011 The block SHALL have port q, output, N bits: current count.
REQ-012 The block SHALL have port max_tick, output, 1 bit: combinational; high exactly when q equals M-1.
REQ-013 The block SHALL have port min_tick, output, 1 bit: combinational; high exactly when q equals 0.
REQ-014 The block SHALL have port wrap, output, 1 bit: registered; a one-cycle pulse after each wrap.
REQ-015 The block SHALL have port done, output, 1 bit: registered; high while the state is HALT.

Function
REQ-016 Per-edge priority SHALL be clr > load > count (en) > hold.
REQ-017 With clr=1, the block SHALL set q to 0, set the state to RUN and clear wrap on the next edge, regardless of load, en or the state.
REQ-018 With load=1 and clr=0, the block SHALL set q to d on the next edge, or to M-1 if d >= M, and set the state to RUN; wrap is not asserted.
REQ-019 The block SHALL have a two-state machine: RUN (counting) and HALT (q frozen, done=1).
REQ-020 In RUN with en=1 and up=1, the block SHALL advance q by 1; at q=M-1, it SHALL set q to 0 if oneshot=0, else keep q=M-1 and enter HALT.
REQ-021 In RUN with en=1 and up=0, the block SHALL decrement q by 1; at q=0, it SHALL set q to M-1 if oneshot=0, else keep q=0 and enter HALT.
REQ-022 The terminal test SHALL use the current up value only; reversing direction at the terminal count is legal and simply counts away from it.
REQ-023 In RUN with en=0, the block SHALL hold q and the state.
REQ-024 In HALT, the block SHALL ignore en, up and oneshot; only clr, load or rst exit HALT.
REQ-025 The block SHALL assert wrap for exactly the one cycle following an edge on which q wrapped (M-1 to 0 or 0 to M-1) via counting; at all other times wrap SHALL be 0.
REQ-026 Entering HALT SHALL NOT assert wrap.
REQ-027 For M = 2**N, wrap arithmetic SHALL be natural modulo 2**N; for M < 2**N, q SHALL never exceed M-1 after any legal operation.
REQ-028 The block SHALL produce no pipeline latency on q: q reflects the operation of the previous edge; max_tick and min_tick SHALL follow q combinationally in the same cycle.

Reset
REQ-029 While rst=1, the block SHALL immediately and asynchronously force q=0, state=RUN, wrap=0 and done=0; consequently max_tick=0 and min_tick=1.
REQ-030 Reset asserted mid-count or while in HALT SHALL abandon that state; after rst is released, counting SHALL resume from 0 on the first edge with en=1.

Verification
REQ-031 The bench SHALL check: N=4, M=10, up=1, oneshot=0, en=1 for 12 edges from reset -> q runs 1..9, 0, 1, 2; max_tick is high at q=9; wrap is high for one cycle while q=0.
REQ-032 The bench SHALL check: N=4, M=10, up=0 from reset -> first edge gives q=9 and a wrap pulse; min_tick is high before that edge.
REQ-033 The bench SHALL check: oneshot=1, up=1, load d=7, M=10 -> q goes 7, 8, 9 and then holds at 9; done=1 from the edge after q=9 is reached; wrap is never asserted; en toggling has no effect; clr then returns q=0 and done=0.
REQ-034 The bench SHALL check: load d=12 with M=10 -> q=9; clr and load both high -> q=0.
REQ-035 The bench SHALL check: rst asserted asynchronously between edges while q=5 and done=1 -> q=0 and done=0 before the next clock edge.
REQ-036 The bench SHALL check: N=8, M=256, free-running up -> q goes 255 to 0 with a wrap pulse, matching plain binary rollover.
